// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - program sequencer feeding opcodes/operands to the Skein ALU (optional ALU_SEQ_REPEAT_EN)
module alu_sequencer #(
  parameter int PROG_DEPTH = 32,
  parameter int ADDR_W     = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              prog_we_i,
  input  logic [ADDR_W-1:0] prog_addr_i,
  input  logic [15:0]       prog_data_i,
  input  logic              start_i,
  input  logic [15:0]       repeat_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic [63:0]       operand_data_i,
  input  logic              operand_valid_i,
  output logic              operand_ready_o,
  output logic [3:0]        alu_opcode_o,
  output logic [63:0]       alu_input_o,
  input  logic [63:0]       alu_result_i,
  output logic [63:0]       result_o,
  output logic              result_valid_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  // Only opcode, OPND, CAPT and LAST are stored; the reserved bits never matter.
  logic [6:0]        mem [PROG_DEPTH];
  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              capt_q;
  logic [6:0]        instr;
  logic              stall;
  logic              at_end;
  logic              last_pass;
  logic              unused_bits;

  assign instr           = mem[pc_q];
  assign stall           = instr[4] && !operand_valid_i;
  assign at_end          = instr[6] || (pc_q == ADDR_W'(PROG_DEPTH - 1));
  assign busy_o          = (state_q != S_IDLE);
  assign operand_ready_o = (state_q == S_RUN) && instr[4];

`ifdef ALU_SEQ_REPEAT_EN
  logic [15:0] pass_q;
  logic [15:0] repeat_q;

  assign last_pass   = (pass_q == repeat_q);
  assign unused_bits = ^prog_data_i[15:7];

  // Pass counter: cleared and loaded at start, advanced at each program wrap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pass_q   <= 16'd0;
      repeat_q <= 16'd0;
    end else if (state_q == S_IDLE && start_i) begin
      pass_q   <= 16'd0;
      repeat_q <= repeat_i;
    end else if (state_q == S_RUN && !stall && at_end && !last_pass) begin
      pass_q   <= pass_q + 16'd1;
    end
  end
`else
  assign last_pass   = 1'b1;
  assign unused_bits = ^{prog_data_i[15:7], repeat_i};
`endif

  // Program memory: loaded only while idle so a running program is never disturbed.
  always_ff @(posedge clk_i) begin
    if (prog_we_i && state_q == S_IDLE) begin
      mem[prog_addr_i] <= prog_data_i[6:0];
    end
  end

  // Sequencer FSM with registered ALU drive, capture and done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= S_IDLE;
      pc_q           <= '0;
      capt_q         <= 1'b0;
      alu_opcode_o   <= 4'h0;
      alu_input_o    <= 64'd0;
      result_o       <= 64'd0;
      result_valid_o <= 1'b0;
      done_o         <= 1'b0;
    end else begin
      done_o         <= 1'b0;
      result_valid_o <= capt_q;
      if (capt_q) begin
        result_o <= alu_result_i;
      end
      case (state_q)
        S_IDLE: begin
          alu_opcode_o <= 4'h0;
          capt_q       <= 1'b0;
          if (start_i) begin
            pc_q    <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (stall) begin
            alu_opcode_o <= 4'h0;
            capt_q       <= 1'b0;
          end else begin
            alu_opcode_o <= instr[3:0];
            capt_q       <= instr[5];
            if (instr[4]) begin
              alu_input_o <= operand_data_i;
            end
            if (at_end) begin
              if (last_pass) begin
                state_q <= S_DRAIN;
              end else begin
                pc_q <= '0;
              end
            end else begin
              pc_q <= pc_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          alu_opcode_o <= 4'h0;
          capt_q       <= 1'b0;
          done_o       <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer
module tb_alu_sequencer;
  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [15:0] prog_data;
  logic        start;
  logic [15:0] repeat_n;
  logic        busy, done;
  logic [63:0] operand_data;
  logic        operand_valid, operand_ready;
  logic [3:0]  alu_opcode;
  logic [63:0] alu_input, alu_result, result;
  logic        result_valid;

  int checks = 0;
  int errors = 0;
  logic [15:0] prog [DEPTH];
  logic [63:0] model_in;

  always #5 clk = ~clk;

  alu_sequencer #(.PROG_DEPTH(DEPTH), .ADDR_W(5)) dut (
    .clk_i(clk), .rst_i(rst), .prog_we_i(prog_we), .prog_addr_i(prog_addr),
    .prog_data_i(prog_data), .start_i(start), .repeat_i(repeat_n),
    .busy_o(busy), .done_o(done), .operand_data_i(operand_data),
    .operand_valid_i(operand_valid), .operand_ready_o(operand_ready),
    .alu_opcode_o(alu_opcode), .alu_input_o(alu_input), .alu_result_i(alu_result),
    .result_o(result), .result_valid_o(result_valid)
  );

  function automatic logic [63:0] res_f(input logic [3:0] op, input logic [63:0] d);
    return {d[59:0], op} ^ 64'h9E37_79B9_7F4A_7C15;
  endfunction

  assign alu_result = res_f(alu_opcode, alu_input);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = 5'(i);
      prog_data = prog[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_opcode"}, 64'(alu_opcode), 64'd0);
    chk({tag, "_input"}, alu_input, 64'd0);
    chk({tag, "_result"}, result, 64'd0);
    chk({tag, "_rvalid"}, 64'(result_valid), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_ready"}, 64'(operand_ready), 64'd0);
  endtask

  // vmode: 0 operand always valid, 1 valid withheld for the first 3 cycles, 2 random valid
  task automatic run(input int rep, input int vmode, input bit disturb,
                     output int busy_cycles, output int issues);
    logic [63:0] opq [$];
    logic [3:0]  eop [$];
    logic [63:0] ein [$];
    logic [63:0] eres [$];
    int passes, pc, ci, oi, ri, cyc;
    bit dn;
    logic [15:0] ins;
    logic [63:0] d;
    passes = 1;
`ifdef ALU_SEQ_REPEAT_EN
    passes = rep + 1;
`endif
    for (int p = 0; p < passes; p++) begin
      pc = 0;
      while (1) begin
        ins = prog[pc];
        if (ins[4]) begin
          d = {$urandom, $urandom};
          opq.push_back(d);
          model_in = d;
        end
        eop.push_back(ins[3:0]);
        ein.push_back(model_in);
        if (ins[5]) eres.push_back(res_f(ins[3:0], model_in));
        if (ins[6] || pc == DEPTH - 1) break;
        pc++;
      end
    end
    @(negedge clk);
    repeat_n = 16'(rep);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ci = 0; oi = 0; ri = 0; cyc = 0; dn = 0; busy_cycles = 0;
    while (cyc < 2000 && !dn) begin
      @(negedge clk);
      if (busy) busy_cycles++;
      if (alu_opcode != 4'h0) begin
        if (oi < eop.size()) begin
          chk("opcode", 64'(alu_opcode), 64'(eop[oi]));
          chk("alu_input", alu_input, ein[oi]);
        end else begin
          chk("extra_issue", 64'(oi), 64'(eop.size()));
        end
        oi++;
      end
      if (result_valid) begin
        if (ri < eres.size()) chk("result", result, eres[ri]);
        else chk("extra_result", 64'(ri), 64'(eres.size()));
        ri++;
      end
      if (done) begin
        dn = 1;
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_ready", 64'(operand_ready), 64'd0);
      end
      if (vmode == 1 && cyc < 3) begin
        operand_valid = 1'b0;
        chk("stall_ready", 64'(operand_ready), 64'd1);
        chk("stall_nop", 64'(alu_opcode), 64'd0);
      end else if (vmode == 2) begin
        operand_valid = 1'($urandom_range(0, 1));
      end else begin
        operand_valid = 1'b1;
      end
      operand_data = (ci < opq.size()) ? opq[ci] : {$urandom, $urandom};
      if (disturb && cyc == 1) begin
        prog_we   = 1'b1;
        prog_addr = 5'd0;
        prog_data = 16'h00CF;
        start     = 1'b1;
      end else begin
        prog_we = 1'b0;
        start   = 1'b0;
      end
      if (operand_ready && operand_valid) ci++;
      cyc++;
    end
    operand_valid = 1'b0;
    chk("done_seen", 64'(dn), 64'd1);
    chk("issue_count", 64'(oi), 64'(eop.size()));
    chk("result_count", 64'(ri), 64'(eres.size()));
    chk("operand_count", 64'(ci), 64'(opq.size()));
    issues = oi;
    @(negedge clk);
    chk("post_busy", 64'(busy), 64'd0);
    chk("post_done", 64'(done), 64'd0);
    chk("post_rvalid", 64'(result_valid), 64'd0);
  endtask

  initial begin
    int bc, is, exp_passes, len, dn_cnt;
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0;
    repeat_n = '0; operand_data = '0; operand_valid = 1'b0; model_in = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Two-instruction program, operand always valid
    for (int i = 0; i < DEPTH; i++) prog[i] = 16'h0001;
    prog[0] = 16'h0031;
    prog[1] = 16'h0062;
    load_prog();
    run(0, 0, 0, bc, is);
    chk("basic_busy_cycles", 64'(bc), 64'd3);
    chk("basic_issues", 64'(is), 64'd2);

    // Same program with a 3-cycle operand stall
    run(0, 1, 0, bc, is);
    chk("stall_busy_cycles", 64'(bc), 64'd6);

    // Repeat passes
    exp_passes = 1;
`ifdef ALU_SEQ_REPEAT_EN
    exp_passes = 3;
`endif
    run(2, 0, 0, bc, is);
    chk("repeat_issues", 64'(is), 64'(2 * exp_passes));

    // No LAST anywhere: implicit end at the final slot, reserved bits random
    for (int i = 0; i < DEPTH; i++)
      prog[i] = {9'($urandom), 1'b0, 2'($urandom), 4'($urandom_range(1, 15))};
    load_prog();
    run(0, 2, 0, bc, is);
    chk("implicit_end_issues", 64'(is), 64'(DEPTH));

    // Reset in the middle of a run
    @(negedge clk);
    operand_valid = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1 check_reset_outputs("midrun_reset");
    @(negedge clk);
    rst = 1'b0;
    operand_valid = 1'b0;
    model_in = '0;
    dn_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) dn_cnt++;
    end
    chk("no_done_after_reset", 64'(dn_cnt), 64'd0);
    run(0, 0, 0, bc, is);
    chk("after_reset_issues", 64'(is), 64'(DEPTH));

    // Program write and start while busy are ignored
    for (int i = 0; i < DEPTH; i++) prog[i] = 16'h0001;
    prog[0] = 16'h0033;
    prog[1] = 16'h0025;
    prog[2] = 16'h0017;
    prog[3] = 16'h0069;
    load_prog();
    run(1, 0, 1, bc, is);
    run(0, 0, 0, bc, is);
    chk("busy_write_issues", 64'(is), 64'(4 * 1));

    // Random programs with random operand availability
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, DEPTH);
      for (int i = 0; i < DEPTH; i++)
        prog[i] = {9'($urandom), (i == len - 1) ? 1'b1 : 1'b0, 2'($urandom),
                   4'($urandom_range(1, 15))};
      load_prog();
      run($urandom_range(0, 3), 2, 0, bc, is);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
